// File: rtl/seq_pkg.sv
// Shared types and widths for the instruction sequencer and its program memory.
package seq_pkg;

   localparam int unsigned OPC_W   = 3;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned FUNC_W  = OPC_W + 2 * REG_W;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ENTRY_W = FUNC_W + DATA_W;

   localparam logic [FUNC_W-1:0] NOP_FUNC = 9'h000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   // One program memory entry: func word in the upper bits, data operand below.
   typedef struct packed {
      logic [FUNC_W-1:0] opFunc;
      logic [DATA_W-1:0] operand;
   } prog_word_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous write, asynchronous read, contents never reset.
module prog_mem
   import seq_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic               clock,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wrAddr,
   input  logic [ENTRY_W-1:0] wrData,
   input  logic [ADDR_W-1:0]  rdAddr,
   output logic [ENTRY_W-1:0] rdData
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a loaded program of func/data words to the processor, one per clock,
// with stall support and a one-cycle completion pulse.
module instruction_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              progWe,
   input  logic [ADDR_W-1:0] progAddr,
   input  logic [8:0]        progFunc,
   input  logic [7:0]        progData,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   input  logic              stall,
   output logic [8:0]        func,
   output logic [7:0]        procData,
   output logic              issueValid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pc
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   seq_state_t        state;
   logic [CNT_W-1:0]  lenReg;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  lenClamped;
   logic              memWe;
   prog_word_t        wrWord;
   prog_word_t        rdWord;

   assign lenClamped = (length > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : length;
   assign memWe      = progWe && (state == IDLE);
   assign wrWord     = '{opFunc: progFunc, operand: progData};

   prog_mem #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) uMem (
      .clock (clock),
      .we    (memWe),
      .wrAddr(progAddr),
      .wrData(wrWord),
      .rdAddr(pc),
      .rdData(rdWord)
   );

   // Outputs default to NOP each cycle; only an unstalled RUN cycle issues a word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         func       <= NOP_FUNC;
         procData   <= '0;
         issueValid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pc         <= '0;
         lenReg     <= '0;
         issued     <= '0;
      end else begin
         func       <= NOP_FUNC;
         procData   <= '0;
         issueValid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lenReg <= lenClamped;
                  pc     <= '0;
                  issued <= '0;
                  if (lenClamped == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issued == lenReg) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (!stall) begin
                  func       <= rdWord.opFunc;
                  procData   <= rdWord.operand;
                  issueValid <= 1'b1;
                  pc         <= pc + ADDR_W'(1);
                  issued     <= issued + CNT_W'(1);
               end
            end
            DONE: begin
               // A zero-length start enters here with done low; raise it for one cycle first.
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed and randomized checks of instruction_sequencer against a cycle-level model of issue order.
module tb_instruction_sequencer;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              progWe;
   logic [ADDR_W-1:0] progAddr;
   logic [8:0]        progFunc;
   logic [7:0]        progData;
   logic              start;
   logic [ADDR_W:0]   length;
   logic              stall;
   logic [8:0]        func;
   logic [7:0]        procData;
   logic              issueValid;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] pc;

   int checks = 0;
   int errors = 0;

   logic [16:0] modelMem [DEPTH];

   instruction_sequencer #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .progWe    (progWe),
      .progAddr  (progAddr),
      .progFunc  (progFunc),
      .progData  (progData),
      .start     (start),
      .length    (length),
      .stall     (stall),
      .func      (func),
      .procData  (procData),
      .issueValid(issueValid),
      .busy      (busy),
      .done      (done),
      .pc        (pc)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutputs(input string tag, input logic [31:0] expFunc, input logic [31:0] expData,
                               input logic [31:0] expValid, input logic [31:0] expBusy,
                               input logic [31:0] expDone, input logic [31:0] expPc);
      check({tag, ".func"}, 32'(func), expFunc);
      check({tag, ".procData"}, 32'(procData), expData);
      check({tag, ".issueValid"}, 32'(issueValid), expValid);
      check({tag, ".busy"}, 32'(busy), expBusy);
      check({tag, ".done"}, 32'(done), expDone);
      check({tag, ".pc"}, 32'(pc), expPc);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic loadWord(input int addr, input logic [8:0] f, input logic [7:0] d);
      progWe   = 1'b1;
      progAddr = ADDR_W'(addr);
      progFunc = f;
      progData = d;
      tick();
      progWe = 1'b0;
      modelMem[addr] = {f, d};
   endtask

   // Model: after start, each unstalled cycle shows the next program word; once
   // all min(length,DEPTH) words are out, one cycle of done, then idle.
   task automatic runProgram(input string tag, input int reqLen, input logic [31:0] stallMask,
                             input bit disturb);
      int n;
      int issued;
      int c;
      n = (reqLen > int'(DEPTH)) ? int'(DEPTH) : reqLen;
      start  = 1'b1;
      length = (ADDR_W+1)'(reqLen);
      tick();
      start = 1'b0;
      checkOutputs({tag, ".start"}, 0, 0, 0, (n != 0) ? 1 : 0, 0, 0);
      issued = 0;
      c      = 0;
      while (issued < n) begin
         stall = (c < 32) ? stallMask[c] : 1'b0;
         if (disturb) begin
            progWe   = 1'b1;
            progAddr = ADDR_W'($urandom);
            progFunc = 9'($urandom);
            progData = 8'($urandom);
            start    = 1'b1;
            length   = (ADDR_W+1)'($urandom);
         end
         tick();
         if (stall) begin
            checkOutputs({tag, ".stall"}, 0, 0, 0, 1, 0, 32'(issued % int'(DEPTH)));
         end else begin
            checkOutputs({tag, ".issue"}, 32'(modelMem[issued][16:8]), 32'(modelMem[issued][7:0]),
                         1, 1, 0, 32'((issued + 1) % int'(DEPTH)));
            issued++;
         end
         c++;
      end
      stall  = 1'b0;
      progWe = 1'b0;
      start  = 1'b0;
      tick();
      checkOutputs({tag, ".done"}, 0, 0, 0, 0, 1, 32'(n % int'(DEPTH)));
      tick();
      checkOutputs({tag, ".idle"}, 0, 0, 0, 0, 0, 32'(n % int'(DEPTH)));
   endtask

   initial begin
      reset    = 1'b1;
      progWe   = 1'b0;
      progAddr = '0;
      progFunc = '0;
      progData = '0;
      start    = 1'b0;
      length   = '0;
      stall    = 1'b0;
      repeat (2) tick();
      checkOutputs("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();

      loadWord(0, 9'h0C8, 8'h05);
      loadWord(1, 9'h10A, 8'h00);
      loadWord(2, 9'h051, 8'h00);
      runProgram("basic3", 3, 32'h0, 1'b0);
      runProgram("stall2", 3, 32'b110, 1'b0);
      runProgram("len0", 0, 32'h0, 1'b0);

      for (int i = 0; i < int'(DEPTH); i++) begin
         loadWord(i, 9'($urandom), 8'($urandom));
      end
      runProgram("len20", 20, 32'h0, 1'b0);

      runProgram("disturb", 5, $urandom & $urandom, 1'b1);
      runProgram("rerun", 16, 32'h0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         runProgram("random", int'($urandom_range(0, 20)), $urandom & $urandom, 1'b0);
      end

      start  = 1'b1;
      length = 5'd16;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("midrun.func", 32'(func), 32'(modelMem[2][16:8]));
      #2 reset = 1'b1;
      #1;
      checkOutputs("asyncReset", 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      runProgram("afterReset", 16, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
